// File: rtl/pc_adder.sv
// Next-sequential-PC generator for the fetch stage.
// The combinational PC+INCR path feeds the next-PC mux directly. A registered
// copy of the sum and its status flags is kept for pipeline and debug logic.
module pc_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INCR  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcAddr,
  output logic [WIDTH-1:0] pcAddr_q,
  output logic             wrap,
  output logic             wrap_q,
  output logic             misaligned,
  output logic             misaligned_q,
  output logic             valid_q
);

  // The increment is widened by one bit so that the sum exposes the carry-out
  // as its top bit. Wrap is the carry-out of the WIDTH-bit add.
  localparam logic [WIDTH:0] INCR_W = (WIDTH+1)'(INCR);

  // Everything captured per edge is kept in one struct so that the reset
  // value and the load path stay in step.
  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic             wrap;
    logic             mis;
    logic             vld;
  } pc_stat_t;

  logic [WIDTH:0] sum;
  pc_stat_t       stat_d, stat_q;

  // Combinational increment. It does not depend on clk or rst_n, so the
  // next-PC mux gets a correct value even before the first clock edge.
  // Low bits pass straight through the add, and no alignment is forced.
  always_comb begin
    sum        = {1'b0, pc} + INCR_W;
    pcAddr     = sum[WIDTH-1:0];
    wrap       = sum[WIDTH];
    misaligned = |pc[1:0];
  end

  // Next-state for the output register. valid is tied high, so it rises on
  // the first edge after reset release and stays high until the next reset.
  always_comb begin
    stat_d      = '0;
    stat_d.addr = pcAddr;
    stat_d.wrap = wrap;
    stat_d.mis  = misaligned;
    stat_d.vld  = 1'b1;
  end

  // Output register. An asynchronous clear means that a reset asserted
  // mid-cycle clears the outputs without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign pcAddr_q     = stat_q.addr;
  assign wrap_q       = stat_q.wrap;
  assign misaligned_q = stat_q.mis;
  assign valid_q      = stat_q.vld;

endmodule

// File: tb/tb_pc_adder.sv
// Directed bench for pc_adder. The expected values are worked out by hand.
module tb_pc_adder;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         clk_en;
  logic [W-1:0] pc;
  logic [W-1:0] pcAddr, pcAddr_q;
  logic         wrap, wrap_q, misaligned, misaligned_q, valid_q;

  int nvec = 0;
  int nmis = 0;

  pc_adder #(.WIDTH(W), .INCR(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .pcAddr(pcAddr), .pcAddr_q(pcAddr_q),
    .wrap(wrap), .wrap_q(wrap_q),
    .misaligned(misaligned), .misaligned_q(misaligned_q),
    .valid_q(valid_q)
  );

  // The clock is gated so that the first checks run with clk idle.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk_en = 1'b0;
    // Combinational path with no clock and rst_n not yet driven.
    pc = 32'h0000_0000; #10;
    chk("c0_addr", 64'(pcAddr), 64'h4);
    chk("c0_wrap", 64'(wrap), 64'h0);
    chk("c0_mis", 64'(misaligned), 64'h0);
    pc = 32'h0000_0012; #1;
    chk("c12_addr", 64'(pcAddr), 64'h16);
    chk("c12_mis", 64'(misaligned), 64'h1);
    pc = 32'h0000_0008; #1;
    chk("c8_addr", 64'(pcAddr), 64'hC);
    chk("c8_mis", 64'(misaligned), 64'h0);
    pc = 32'h0001_0000; #1;
    chk("c10000_addr", 64'(pcAddr), 64'h10004);
    chk("c10000_wrap", 64'(wrap), 64'h0);
    pc = 32'hFFFF_FFFC; #1;
    chk("cwrap_addr", 64'(pcAddr), 64'h0);
    chk("cwrap_wrap", 64'(wrap), 64'h1);
    chk("cwrap_mis", 64'(misaligned), 64'h0);
    pc = 32'hFFFF_FFFB; #1;
    chk("cwrap2_addr", 64'(pcAddr), 64'hFFFF_FFFF);
    chk("cwrap2_wrap", 64'(wrap), 64'h0);

    // Hold reset while the clock runs. Only the combinational outputs follow.
    rst_n = 1'b0; pc = 32'h100; clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_q", 64'(pcAddr_q), 64'h0);
    chk("rst_valid", 64'(valid_q), 64'h0);
    chk("rst_wrap_q", 64'(wrap_q), 64'h0);
    chk("rst_addr", 64'(pcAddr), 64'h104);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_addr_q", 64'(pcAddr_q), 64'h104);
    chk("rel_valid", 64'(valid_q), 64'h1);
    chk("rel_mis_q", 64'(misaligned_q), 64'h0);

    // Capture the registered wrap and misaligned flags.
    pc = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    chk("q_addr_wrap", 64'(pcAddr_q), 64'h2);
    chk("q_wrap", 64'(wrap_q), 64'h1);
    chk("q_mis", 64'(misaligned_q), 64'h1);
    pc = 32'h200;
    @(posedge clk); #1;
    chk("q200_addr", 64'(pcAddr_q), 64'h204);
    chk("q200_wrap", 64'(wrap_q), 64'h0);
    chk("q200_valid", 64'(valid_q), 64'h1);
    pc = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("qff_mis", 64'(misaligned_q), 64'h1);

    // A reset asserted between edges clears the registers immediately.
    #1 rst_n = 1'b0; #1;
    chk("arst_addr_q", 64'(pcAddr_q), 64'h0);
    chk("arst_wrap_q", 64'(wrap_q), 64'h0);
    chk("arst_mis_q", 64'(misaligned_q), 64'h0);
    chk("arst_valid", 64'(valid_q), 64'h0);
    chk("arst_addr", 64'(pcAddr), 64'h3);

    // A change to pc in the middle of a cycle reaches the combinational
    // outputs at once and the registered outputs on the next edge.
    @(negedge clk);
    rst_n = 1'b1; pc = 32'h20;
    @(posedge clk); #1;
    chk("mid_addr_q0", 64'(pcAddr_q), 64'h24);
    #2 pc = 32'h30; #1;
    chk("mid_addr", 64'(pcAddr), 64'h34);
    chk("mid_addr_q1", 64'(pcAddr_q), 64'h24);
    @(posedge clk); #1;
    chk("mid_addr_q2", 64'(pcAddr_q), 64'h34);
    chk("mid_valid", 64'(valid_q), 64'h1);

    clk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
